// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencing controller: memory-access
// FSM encoding and the hardwired-zero register index.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no data-memory access outstanding
        ST_WAIT = 2'd1,   // request issued, waiting for the ack pulse
        ST_DONE = 2'd2    // ack seen; pipeline advances at the end of this cycle
    } mem_state_e;

    // Register r0 is hardwired to zero, so a load targeting it never creates a hazard.
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare: the load in EX writes a register
// that the instruction in ID reads.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       idex_mem_read_i,
    input  logic [4:0] idex_rt_i,
    input  logic [4:0] ifid_rs_i,
    input  logic [4:0] ifid_rt_i,
    output logic       hazard_o
);

    // Hazard only for a real (non-r0) load destination matching either ID source.
    always_comb begin
        hazard_o = idex_mem_read_i
                 && (idex_rt_i != REG_ZERO)
                 && ((idex_rt_i == ifid_rs_i) || (idex_rt_i == ifid_rt_i));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage core. Generates stall,
// bubble and flush controls from load-use hazards, taken branches and a
// req/ack data-memory handshake that freezes the whole pipeline.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             idex_memRead_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             branch_taken_i,
    input  logic             exmem_memRead_i,
    input  logic             exmem_memWrite_i,
    input  logic             mem_ack_i,
    output logic             mem_req_o,
    output logic             pc_stall_o,
    output logic             ifid_stall_o,
    output logic             idex_stall_o,
    output logic             exmem_stall_o,
    output logic             memwb_stall_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             mem_timeout_o
);

    localparam int                TMO_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0]  TMO_MAX = TMO_W'(TIMEOUT_CYC);

    mem_state_e       state_q, state_d;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_q, timeout_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic access;
    logic freeze;
    logic hazard;

    load_use_detect u_load_use_detect (
        .idex_mem_read_i (idex_memRead_i),
        .idex_rt_i       (idex_rt_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .hazard_o        (hazard)
    );

    // Memory access request and the resulting whole-pipeline freeze.
    always_comb begin
        access = exmem_memRead_i | exmem_memWrite_i;
        freeze = ((state_q == ST_IDLE) && access) || (state_q == ST_WAIT);
    end

    // Memory FSM next state; access is ignored in DONE since the same instruction is still in MEM.
    always_comb begin
        // NOTE: every variable written here gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (access)    state_d = mem_ack_i ? ST_DONE : ST_WAIT;
            ST_WAIT: if (mem_ack_i) state_d = ST_DONE;
            ST_DONE:                state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // WAIT-cycle counter (cleared outside WAIT) and sticky timeout flag.
    always_comb begin
        tmo_cnt_d = '0;
        timeout_d = timeout_q;
        if ((state_q == ST_WAIT) && !mem_ack_i) begin
            tmo_cnt_d = (tmo_cnt_q == TMO_MAX) ? tmo_cnt_q : tmo_cnt_q + TMO_W'(1);
            if (tmo_cnt_d == TMO_MAX) begin
                timeout_d = 1'b1;
            end
        end
    end

    // Output priority: freeze > load-use > branch flush; everything forced low in reset.
    always_comb begin
        mem_req_o     = 1'b0;
        pc_stall_o    = 1'b0;
        ifid_stall_o  = 1'b0;
        idex_stall_o  = 1'b0;
        exmem_stall_o = 1'b0;
        memwb_stall_o = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b0;
        if (rst_n_i) begin
            mem_req_o = freeze;
            if (freeze) begin
                pc_stall_o    = 1'b1;
                ifid_stall_o  = 1'b1;
                idex_stall_o  = 1'b1;
                exmem_stall_o = 1'b1;
                memwb_stall_o = 1'b1;
            end else if (hazard) begin
                pc_stall_o    = 1'b1;
                ifid_stall_o  = 1'b1;
                idex_bubble_o = 1'b1;
            end else if (branch_taken_i) begin
                ifid_flush_o  = 1'b1;
            end
        end
    end

    // Saturating count of cycles with the PC held.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (pc_stall_o && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // State, counters and timeout flag registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q     <= ST_IDLE;
            tmo_cnt_q   <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q     <= state_d;
            tmo_cnt_q   <= tmo_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt_o   = stall_cnt_q;
    assign mem_timeout_o = timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl. Memory transactions are modelled
// as scripted windows (N+1 frozen cycles then one completion cycle); the
// hazard/branch priority and the stall counter are computed from the rules.
module tb_pipe_hazard_ctrl;

    localparam int CNT_W       = 4;
    localparam int TIMEOUT_CYC = 4;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk;
    logic             rst_n;
    logic [4:0]       ifid_rs, ifid_rt, idex_rt;
    logic             idex_memRead, branch_taken;
    logic             exmem_memRead, exmem_memWrite, mem_ack;
    logic             mem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall;
    logic             ifid_flush, idex_bubble, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;
    logic [7:0]       outs;

    int tests = 0;
    int fails = 0;
    int model_cnt = 0;
    bit model_to = 1'b0;

    pipe_hazard_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk_i            (clk),
        .rst_n_i          (rst_n),
        .ifid_rs_i        (ifid_rs),
        .ifid_rt_i        (ifid_rt),
        .idex_memRead_i   (idex_memRead),
        .idex_rt_i        (idex_rt),
        .branch_taken_i   (branch_taken),
        .exmem_memRead_i  (exmem_memRead),
        .exmem_memWrite_i (exmem_memWrite),
        .mem_ack_i        (mem_ack),
        .mem_req_o        (mem_req),
        .pc_stall_o       (pc_stall),
        .ifid_stall_o     (ifid_stall),
        .idex_stall_o     (idex_stall),
        .exmem_stall_o    (exmem_stall),
        .memwb_stall_o    (memwb_stall),
        .ifid_flush_o     (ifid_flush),
        .idex_bubble_o    (idex_bubble),
        .stall_cnt_o      (stall_cnt),
        .mem_timeout_o    (mem_timeout)
    );

    assign outs = {mem_req, pc_stall, ifid_stall, idex_stall, exmem_stall, memwb_stall,
                   ifid_flush, idex_bubble};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One unfrozen-or-frozen cycle: inputs already driven at the negedge.
    task automatic run_cycle(input bit frz, input string tag);
        logic       haz;
        logic [7:0] exp_v;
        #1;
        haz = idex_memRead && (idex_rt != 5'd0) && (idex_rt == ifid_rs || idex_rt == ifid_rt);
        if (frz)               exp_v = 8'b1_11111_00;
        else if (haz)          exp_v = 8'b0_11000_01;
        else if (branch_taken) exp_v = 8'b0_00000_10;
        else                   exp_v = 8'b0_00000_00;
        check({tag, "_ctl"}, 32'(outs), 32'(exp_v));
        check({tag, "_cnt"}, 32'(stall_cnt), 32'(model_cnt));
        check({tag, "_tmo"}, 32'(mem_timeout), 32'(model_to));
        if (exp_v[6] && model_cnt < CNT_MAX) model_cnt++;
        @(negedge clk);
    endtask

    task automatic rand_id();
        idex_memRead = 1'($urandom_range(0, 1));
        idex_rt      = 5'($urandom_range(0, 3));
        ifid_rs      = 5'($urandom_range(0, 3));
        ifid_rt      = 5'($urandom_range(0, 3));
        branch_taken = 1'($urandom_range(0, 1));
    endtask

    // Access with ack n cycles after the request: n+1 frozen cycles, then the completion cycle.
    task automatic mem_txn(input int n, input bit hold, input string tag);
        bit is_rd;
        is_rd = 1'($urandom_range(0, 1));
        for (int k = 0; k <= n; k++) begin
            if (!hold) rand_id();
            exmem_memRead  = is_rd;
            exmem_memWrite = !is_rd;
            mem_ack        = (k == n);
            run_cycle(1'b1, tag);
        end
        if (!hold) rand_id();
        mem_ack = 1'($urandom_range(0, 1));
        run_cycle(1'b0, {tag, "_done"});
        exmem_memRead  = 1'b0;
        exmem_memWrite = 1'b0;
        mem_ack        = 1'b0;
    endtask

    initial begin
        // Reset with every trigger active: outputs must stay low.
        rst_n = 1'b0;
        exmem_memRead = 1'b1; exmem_memWrite = 1'b0; mem_ack = 1'b0;
        idex_memRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd0;
        branch_taken = 1'b1;
        @(negedge clk);
        #1;
        check("reset_ctl", 32'(outs), 32'h0);
        @(negedge clk);
        #1;
        check("reset_cnt", 32'(stall_cnt), 32'h0);
        check("reset_tmo", 32'(mem_timeout), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        exmem_memRead = 1'b0; idex_memRead = 1'b0; branch_taken = 1'b0;

        // Load-use: one-cycle stall, counter reaches 1.
        idex_memRead = 1'b1; idex_rt = 5'd8; ifid_rs = 5'd8; ifid_rt = 5'd3;
        run_cycle(1'b0, "lu");
        idex_memRead = 1'b0;
        run_cycle(1'b0, "lu_clear");
        check("lu_cnt1", 32'(stall_cnt), 32'd1);
        // Load into r0 is not a hazard.
        idex_memRead = 1'b1; idex_rt = 5'd0; ifid_rs = 5'd0; ifid_rt = 5'd0;
        run_cycle(1'b0, "lu_r0");
        // rt-field match.
        idex_rt = 5'd12; ifid_rs = 5'd1; ifid_rt = 5'd12;
        run_cycle(1'b0, "lu_rt");
        idex_memRead = 1'b0;

        // Taken branch flushes IF/ID without stalling the PC.
        branch_taken = 1'b1;
        run_cycle(1'b0, "br");
        branch_taken = 1'b0;
        run_cycle(1'b0, "br_clear");

        // Memory read with ack 3 cycles after request; then ack in request cycle.
        mem_txn(3, 1'b1, "mem3");
        run_cycle(1'b0, "mem3_idle");
        mem_txn(0, 1'b1, "mem0");

        // Freeze, load-use and branch together; then load-use, then flush.
        idex_memRead = 1'b1; idex_rt = 5'd5; ifid_rs = 5'd5; ifid_rt = 5'd0;
        branch_taken = 1'b1;
        mem_txn(2, 1'b1, "simul");
        idex_memRead = 1'b0;
        run_cycle(1'b0, "simul_br");
        branch_taken = 1'b0;

        // Randomized mix of idle cycles (with stray acks) and memory transactions.
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                mem_txn(int'($urandom_range(0, 3)), 1'b0, "rnd_mem");
            end else begin
                rand_id();
                exmem_memRead = 1'b0; exmem_memWrite = 1'b0;
                mem_ack = 1'($urandom_range(0, 1));
                run_cycle(1'b0, "rnd_idle");
            end
        end
        mem_ack = 1'b0;

        // Timeout: request cycle plus four WAIT cycles without ack sets the flag.
        idex_memRead = 1'b0; branch_taken = 1'b0;
        exmem_memRead = 1'b1; exmem_memWrite = 1'b0; mem_ack = 1'b0;
        for (int k = 0; k < 10; k++) begin
            model_to = (k >= 5);
            run_cycle(1'b1, "tmo_wait");
        end
        mem_ack = 1'b1;
        run_cycle(1'b1, "tmo_ack");
        mem_ack = 1'b0;
        run_cycle(1'b0, "tmo_done");
        exmem_memRead = 1'b0;
        run_cycle(1'b0, "tmo_sticky");

        // Reset in WAIT: everything drops at once; a late ack in IDLE is ignored.
        exmem_memRead = 1'b1;
        for (int k = 0; k < 3; k++) run_cycle(1'b1, "rstw_wait");
        #1;
        rst_n = 1'b0;
        #1;
        check("rstw_ctl", 32'(outs), 32'h0);
        check("rstw_cnt", 32'(stall_cnt), 32'h0);
        check("rstw_tmo", 32'(mem_timeout), 32'h0);
        model_cnt = 0;
        model_to  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exmem_memRead = 1'b0; mem_ack = 1'b1;
        run_cycle(1'b0, "rstw_late_ack");
        mem_ack = 1'b0;
        mem_txn(1, 1'b1, "rstw_next");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Pipeline sequencing controller for the 5-stage core. It generates the stall, bubble and flush controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards and taken branches, and freezes the whole pipeline during multi-cycle data-memory accesses through a req/ack handshake. It sits beside the ID stage; its outputs drive the `stall_i` inputs of the pipeline registers and the control-zeroing mux in front of ID/EX.

## Interface
- `CNT_W`, 16: width of the stall-cycle performance counter.
- `TIMEOUT_CYC`, 255: maximum number of WAIT cycles without an ack before the timeout flag sets (must be at least 1).
- `clk_i` in 1: single clock, rising edge.
- `rst_n_i` in 1: reset, asynchronous, active-low.
- `ifid_rs_i`, `ifid_rt_i` in 5: source register fields of the instruction in ID.
- `idex_memRead_i` in 1: the instruction in EX is a load.
- `idex_rt_i` in 5: destination (rt) of the instruction in EX.
- `branch_taken_i` in 1: the branch resolved in ID is taken.
- `exmem_memRead_i`, `exmem_memWrite_i` in 1: the instruction in MEM accesses data memory.
- `mem_ack_i` in 1: data memory completes the access (single-cycle pulse).
- `mem_req_o` out 1: data-memory request.
- `pc_stall_o`, `ifid_stall_o`, `idex_stall_o`, `exmem_stall_o`, `memwb_stall_o` out 1: hold the corresponding register.
- `ifid_flush_o` out 1: zero the IF/ID instruction (becomes a NOP).
- `idex_bubble_o` out 1: zero the control inputs in front of ID/EX (writeBack, memtoReg, memRead, memWrite, ALUOp).
- `stall_cnt_o` out `CNT_W`: saturating count of cycles with `pc_stall_o` high.
- `mem_timeout_o` out 1: sticky flag, memory access timed out.

## Operation
- **access** = `exmem_memRead_i | exmem_memWrite_i`.
- **Memory FSM** has three states:
  - IDLE: on access, go to WAIT. If `mem_ack_i` arrives in the same cycle, go directly to DONE.
  - WAIT: on `mem_ack_i`, go to DONE.
  - DONE: go to IDLE unconditionally. access is ignored in DONE, because the same instruction is still in MEM.
- **freeze** = (IDLE & access) | WAIT.
  - freeze asserts all five `*_stall_o`.
  - freeze forces `idex_bubble_o` = 0 and `ifid_flush_o` = 0.
- **`mem_req_o`** = (IDLE & access) | WAIT. It is 0 in DONE.
- **Load-use hazard** = `idex_memRead_i` & (`idex_rt_i` != 0) & (`idex_rt_i` == `ifid_rs_i` | `idex_rt_i` == `ifid_rt_i`).
  - When the hazard is present and freeze is low: assert `pc_stall_o`, `ifid_stall_o` and `idex_bubble_o`.
  - `idex_stall_o`, `exmem_stall_o` and `memwb_stall_o` stay 0, so the pipeline drains by one stage.
- **Taken branch**: `branch_taken_i` with no hazard and no freeze asserts `ifid_flush_o` for that cycle. The PC is not stalled.
- **Priority**: freeze > load-use > branch flush. A suppressed branch is re-evaluated on the next unfrozen cycle, because the ID inputs are held.
- **Timeout counter**: counts cycles spent in WAIT and clears on leaving WAIT. When it reaches `TIMEOUT_CYC`, `mem_timeout_o` sets and stays set until reset. The FSM remains in WAIT.
- **`stall_cnt_o`**: increments on each cycle with `pc_stall_o` high and saturates at all-ones.

## Timing
- All control outputs are combinational from the registered state and the current inputs. There is zero latency from a hazard to its stall.
- **Reset**: asynchronous.
  - State, counters and `mem_timeout_o` clear immediately.
  - While `rst_n_i` is low, all stall, flush, bubble and req outputs are forced to 0.
- **Memory penalty**:
  - Minimum penalty is 1 frozen cycle, for an ack in the request cycle.
  - In general the penalty is N+1 cycles for an ack arriving N cycles after the first request; the pipeline advances at the end of the DONE cycle.
- **Load-use penalty**: exactly 1 cycle. On the next cycle the load has left EX, so the hazard clears.
- **Reset during WAIT**: state returns to IDLE and `mem_req_o` drops in the same cycle. Any late ack received in IDLE with access low is ignored.
- **Ack without request** (in IDLE with access low, or in DONE): ignored.

## Structure
- **Package `pipe_ctrl_pkg`**: holds the FSM state encoding (`ST_IDLE`, `ST_WAIT`, `ST_DONE`) and the `REG_ZERO` = 5'd0 constant.
- **Sub-module `load_use_detect`**: purely combinational hazard compare, instantiated once.
- The FSM, both counters and the output priority logic live in the top module.

## Test plan
- **Load-use**: `idex_memRead_i`=1, `idex_rt_i`=8, `ifid_rs_i`=8 → `pc_stall_o`, `ifid_stall_o` and `idex_bubble_o` high for 1 cycle and `stall_cnt_o`=1. The same stimulus with `idex_rt_i`=0 gives no stall.
- **Branch flush**: `branch_taken_i`=1 with no hazard → `ifid_flush_o`=1 for 1 cycle and `pc_stall_o`=0.
- **Memory access**: `exmem_memRead_i`=1 with the ack 3 cycles after the request → `mem_req_o` and all stalls high for 4 cycles, then one DONE cycle with stalls low, then IDLE.
- **Simultaneous events**: freeze, load-use and branch all active → only freeze outputs are asserted; after release, load-use stalls, then the branch flushes.
- **Timeout**: no ack with `TIMEOUT_CYC`=4 → `mem_timeout_o` sets after 4 WAIT cycles and stays set.
- **Reset mid-WAIT**: reset → `mem_req_o` and all stalls 0 immediately, `stall_cnt_o`=0, FSM in IDLE; a later ack is ignored.
